// File: rtl/frame_buf_swap_ctrl.sv
// frame_buf_swap_ctrl: double-buffered frame-buffer write router and vblank-synchronous swap sequencer.
// Optional CLEAR_ON_SWAP_EN fills the new back buffer with CLR_COLOR after each swap.
module frame_buf_swap_ctrl #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24,
    parameter int FRAME_WORDS = 76800,
    parameter logic [DATA_W-1:0] CLR_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_vblank,
    input  logic              draw_swap_req,
    output logic              draw_swap_ack,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ready,
    output logic              front_sel,
    output logic              buf0_we,
    output logic              buf1_we,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic [7:0]        frame_cnt
);
    typedef enum logic [2:0] {
        IDLE, WAIT_VB, SWAP, ACK
`ifdef CLEAR_ON_SWAP_EN
        , CLEAR
`endif
    } state_t;

    localparam logic [ADDR_W:0] FW_L = (ADDR_W+1)'(FRAME_WORDS);

    state_t            state_q;
    logic              front_q, ready_q, we0_q, we1_q, ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        cnt_q;
    logic              acc;
`ifdef CLEAR_ON_SWAP_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
    logic [ADDR_W-1:0] clr_q;
`endif

    // ready_q is only high in IDLE, so this also gates out writes during swap/clear
    assign acc = draw_we & ready_q & ({1'b0, draw_addr} < FW_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            ready_q <= 1'b0;
            we0_q   <= 1'b0;
            we1_q   <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef CLEAR_ON_SWAP_EN
            clr_q   <= '0;
`endif
        end else begin
            we0_q   <= acc & front_q;
            we1_q   <= acc & ~front_q;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            if (acc) begin
                addr_q <= draw_addr;
                data_q <= draw_data;
            end
            case (state_q)
                IDLE: begin
                    if (draw_swap_req) state_q <= WAIT_VB;
                    else ready_q <= 1'b1;
                end
                WAIT_VB: if (vga_vblank) state_q <= SWAP;
                SWAP: begin
                    front_q <= ~front_q;
                    cnt_q   <= cnt_q + 8'd1;
`ifdef CLEAR_ON_SWAP_EN
                    clr_q   <= '0;
                    state_q <= CLEAR;
`else
                    state_q <= ACK;
`endif
                end
`ifdef CLEAR_ON_SWAP_EN
                CLEAR: begin
                    we0_q  <= front_q;
                    we1_q  <= ~front_q;
                    addr_q <= clr_q;
                    data_q <= CLR_COLOR;
                    clr_q  <= clr_q + ADDR_W'(1);
                    if (clr_q == LAST) state_q <= ACK;
                end
`endif
                ACK: begin
                    ack_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign draw_swap_ack = ack_q;
    assign draw_ready    = ready_q;
    assign front_sel     = front_q;
    assign buf0_we       = we0_q;
    assign buf1_we       = we1_q;
    assign buf_wr_addr   = addr_q;
    assign buf_wr_data   = data_q;
    assign frame_cnt     = cnt_q;
endmodule

// File: tb/tb_frame_buf_swap_ctrl.sv
// tb_frame_buf_swap_ctrl: directed + randomized checks of write routing, vblank swap, ack and reset abort.
module tb_frame_buf_swap_ctrl;
    localparam int AW = 17;
    localparam int DW = 24;
    localparam int FW = 16;
    localparam logic [DW-1:0] CLR = 24'h102030;

    logic          clk = 1'b0, rst = 1'b1, vga_vblank = 1'b0, draw_swap_req = 1'b0, draw_we = 1'b0;
    logic [AW-1:0] draw_addr = '0;
    logic [DW-1:0] draw_data = '0;
    logic          draw_swap_ack, draw_ready, front_sel, buf0_we, buf1_we;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic [7:0]    frame_cnt;

    int checks = 0, failures = 0;
    bit mfront = 1'b0;
    int mframes = 0;

    always #5 clk = ~clk;

    frame_buf_swap_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW), .CLR_COLOR(CLR)) dut (
        .clk(clk), .rst(rst), .vga_vblank(vga_vblank), .draw_swap_req(draw_swap_req),
        .draw_swap_ack(draw_swap_ack), .draw_we(draw_we), .draw_addr(draw_addr),
        .draw_data(draw_data), .draw_ready(draw_ready), .front_sel(front_sel),
        .buf0_we(buf0_we), .buf1_we(buf1_we), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .frame_cnt(frame_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected write port: only the back buffer (opposite of the model's front) may be written
    task automatic chk_write(input string tag, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_b0we"}, buf0_we, w & mfront);
        chk({tag, "_b1we"}, buf1_we, w & ~mfront);
        if (w) begin
            chk({tag, "_addr"}, buf_wr_addr, a);
            chk({tag, "_data"}, buf_wr_data, d);
        end
    endtask

    task automatic rand_writes(input int n);
        bit w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 20));
            d = DW'($urandom);
            draw_we = w; draw_addr = a; draw_data = d;
            tick;
            chk("rw_ready", draw_ready, 1);
            chk_write("rw", w && (a < FW), a, d);
        end
        draw_we = 1'b0;
    endtask

    task automatic do_swap(input int gap, input bit vb_with_req, input bit abort);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int n;
        a = AW'($urandom_range(0, FW - 1));
        d = DW'($urandom);
        draw_swap_req = 1'b1; draw_we = 1'b1; draw_addr = a; draw_data = d; vga_vblank = vb_with_req;
        tick;
        vga_vblank = 1'b0; draw_we = 1'b0;
        chk("req_ready", draw_ready, 0);
        chk_write("req_wr", 1'b1, a, d);
        for (int i = 0; i < gap; i++) begin
            draw_we = 1'($urandom_range(0, 1));
            draw_addr = AW'($urandom_range(0, FW - 1));
            tick;
            chk("wait_ready", draw_ready, 0);
            chk_write("wait_wr", 1'b0, '0, '0);
            chk("wait_ack", draw_swap_ack, 0);
            chk("wait_front", front_sel, mfront);
        end
        draw_we = 1'b0; vga_vblank = 1'b1;
        tick;
        vga_vblank = 1'b0;
        chk("vb_front", front_sel, mfront);
        chk("vb_ack", draw_swap_ack, 0);
        tick;
        mfront = ~mfront;
        mframes = (mframes + 1) % 256;
        chk("swap_front", front_sel, mfront);
        chk("swap_cnt", frame_cnt, mframes);
        chk("swap_ack", draw_swap_ack, 0);
        chk("swap_ready", draw_ready, 0);
`ifdef CLEAR_ON_SWAP_EN
        n = abort ? 6 : FW;
        for (int i = 0; i < n; i++) begin
            tick;
            chk_write("clr", 1'b1, AW'(i), CLR);
            chk("clr_ack", draw_swap_ack, 0);
            chk("clr_ready", draw_ready, 0);
        end
`else
        n = 0;
`endif
        if (abort) begin
            rst = 1'b1; draw_swap_req = 1'b0;
            tick;
            rst = 1'b0;
            mfront = 1'b0; mframes = 0;
            chk_write("rst_wr", 1'b0, '0, '0);
            chk("rst_front", front_sel, 0);
            chk("rst_cnt", frame_cnt, 0);
            chk("rst_ack", draw_swap_ack, 0);
            chk("rst_ready", draw_ready, 0);
            for (int i = 0; i < 20; i++) begin
                tick;
                chk("post_rst_ack", draw_swap_ack, 0);
                chk("post_rst_ready", draw_ready, 1);
            end
        end else begin
            tick;
            chk("ack", draw_swap_ack, 1);
            chk("ack_ready", draw_ready, 0);
            chk_write("ack_wr", 1'b0, '0, '0);
            draw_swap_req = 1'b0;
            tick;
            chk("ack_end", draw_swap_ack, 0);
            chk("ready_back", draw_ready, 1);
        end
    endtask

    initial begin
        repeat (3) tick;
        chk("in_rst_ready", draw_ready, 0);
        chk("in_rst_ack", draw_swap_ack, 0);
        rst = 1'b0;
        tick;
        chk("rel_ready", draw_ready, 1);
        chk("rel_front", front_sel, 0);
        chk("rel_cnt", frame_cnt, 0);
        chk_write("rel_wr", 1'b0, '0, '0);
        draw_we = 1'b1; draw_addr = 5; draw_data = 24'hFF0000;
        tick;
        chk_write("wr5", 1'b1, 5, 24'hFF0000);
        draw_addr = 16;
        tick;
        chk_write("wr16", 1'b0, '0, '0);
        draw_we = 1'b0;
        rand_writes(30);
        do_swap(9, 1'b0, 1'b0);
        rand_writes(20);
        do_swap(4, 1'b1, 1'b0);
        for (int k = 0; k < 254; k++) begin
            do_swap($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            rand_writes(2);
        end
        chk("wrap_cnt", frame_cnt, 0);
        do_swap(3, 1'b0, 1'b1);
        rand_writes(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
